// File: rtl/cpu_pkg.sv
// Shared core constants and operand types.
// Imported by write-back, decode and the register file.
package cpu_pkg;
  localparam int XLEN     = 64;
  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]  xword_t;

  localparam reg_idx_t ZERO_IDX = 5'd31;
endpackage

// File: rtl/register_file_if.sv
// Write-back, read and issue bundle of the register file.
// master: pipeline side, slave: register_file.
interface register_file_if;
  import cpu_pkg::*;

  logic     RegWrite;
  reg_idx_t Reg2Write;
  xword_t   Data2Write;
  logic     ReadEn;
  reg_idx_t ReadReg1;
  reg_idx_t ReadReg2;
  xword_t   ReadData1;
  xword_t   ReadData2;
  logic     ReadValid;
  logic     IssueValid;
  reg_idx_t IssueDest;
  logic     Busy1;
  logic     Busy2;

  modport master (
    output RegWrite, Reg2Write, Data2Write,
    output ReadEn, ReadReg1, ReadReg2,
    output IssueValid, IssueDest,
    input  ReadData1, ReadData2, ReadValid,
    input  Busy1, Busy2
  );

  modport slave (
    input  RegWrite, Reg2Write, Data2Write,
    input  ReadEn, ReadReg1, ReadReg2,
    input  IssueValid, IssueDest,
    output ReadData1, ReadData2, ReadValid,
    output Busy1, Busy2
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write bit per register for RAW detection.
// REGFILE_BYPASS_EN: a same-cycle retiring write unblocks Busy.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rd_idx1,
  input  reg_idx_t rd_idx2,
  output logic     busy1,
  output logic     busy2
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  // Set after clear: the newer producer stays outstanding.
  always_comb begin
    pend_d = pend_q;
    if (clr_en)
      pend_d[clr_idx] = 1'b0;
    if (set_en && set_idx != ZERO_IDX)
      pend_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  always_comb begin
    busy1 = pend_q[rd_idx1];
    busy2 = pend_q[rd_idx2];
`ifdef REGFILE_BYPASS_EN
    if (clr_en && clr_idx == rd_idx1)
      busy1 = 1'b0;
    if (clr_en && clr_idx == rd_idx2)
      busy2 = 1'b0;
`endif
    if (rd_idx1 == ZERO_IDX)
      busy1 = 1'b0;
    if (rd_idx2 == ZERO_IDX)
      busy2 = 1'b0;
  end

endmodule

// File: rtl/register_file.sv
// 32x64 register file, two registered read ports, RAW scoreboard.
// REGFILE_BYPASS_EN selects write-first reads; default is read-first.
module register_file
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  register_file_if.slave  rf
);

  xword_t regs_q [NUM_REGS];
  xword_t regs_d [NUM_REGS];
  xword_t rd1_q, rd1_d;
  xword_t rd2_q, rd2_d;
  logic   vld_q, vld_d;

  always_comb begin
    regs_d = regs_q;
    if (rf.RegWrite && rf.Reg2Write != ZERO_IDX)
      regs_d[rf.Reg2Write] = rf.Data2Write;
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    vld_d = rf.ReadEn;
    if (rf.ReadEn) begin
`ifdef REGFILE_BYPASS_EN
      rd1_d = regs_d[rf.ReadReg1];
      rd2_d = regs_d[rf.ReadReg2];
`else
      rd1_d = regs_q[rf.ReadReg1];
      rd2_d = regs_q[rf.ReadReg2];
`endif
      if (rf.ReadReg1 == ZERO_IDX)
        rd1_d = '0;
      if (rf.ReadReg2 == ZERO_IDX)
        rd2_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      vld_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      vld_q  <= vld_d;
    end
  end

  assign rf.ReadData1 = rd1_q;
  assign rf.ReadData2 = rd2_q;
  assign rf.ReadValid = vld_q;

  reg_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (rf.IssueValid),
    .set_idx (rf.IssueDest),
    .clr_en  (rf.RegWrite),
    .clr_idx (rf.Reg2Write),
    .rd_idx1 (rf.ReadReg1),
    .rd_idx2 (rf.ReadReg2),
    .busy1   (rf.Busy1),
    .busy2   (rf.Busy2)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file.
// Follows REGFILE_BYPASS_EN when compiled with it.
module tb_register_file;
  import cpu_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    xword_t d1;
    xword_t d2;
    logic   v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_run = 0;
  int   n_fail = 0;

  exp_t   exp_q [$];
  exp_t   last;
  xword_t m_regs [NUM_REGS];
  logic [NUM_REGS-1:0] m_sb;

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic xword_t mread(reg_idx_t i, logic we,
                                   reg_idx_t wa, xword_t wd);
    if (i == ZERO_IDX)
      return '0;
    if (BYP && we && wa == i)
      return wd;
    return m_regs[i];
  endfunction

  function automatic logic mbusy(reg_idx_t i, logic we,
                                 reg_idx_t wa);
    if (i == ZERO_IDX)
      return 1'b0;
    if (BYP && we && wa == i)
      return 1'b0;
    return m_sb[i];
  endfunction

  task automatic step(input logic rst, input logic we,
                      input reg_idx_t wa, input xword_t wd,
                      input logic re, input reg_idx_t r1,
                      input reg_idx_t r2, input logic iv,
                      input reg_idx_t id);
    exp_t e;
    @(negedge clk);
    rst_n          = rst;
    bus.RegWrite   = we;
    bus.Reg2Write  = wa;
    bus.Data2Write = wd;
    bus.ReadEn     = re;
    bus.ReadReg1   = r1;
    bus.ReadReg2   = r2;
    bus.IssueValid = iv;
    bus.IssueDest  = id;
    #1;
    if (rst) begin
      chk("busy1", {63'd0, bus.Busy1},
          {63'd0, mbusy(r1, we, wa)});
      chk("busy2", {63'd0, bus.Busy2},
          {63'd0, mbusy(r2, we, wa)});
    end
    if (!rst) begin
      e.d1 = '0; e.d2 = '0; e.v = 1'b0;
    end else if (re) begin
      e.d1 = mread(r1, we, wa, wd);
      e.d2 = mread(r2, we, wa, wd);
      e.v  = 1'b1;
    end else begin
      e.d1 = last.d1; e.d2 = last.d2; e.v = 1'b0;
    end
    exp_q.push_back(e);
    last = e;
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        m_regs[i] = '0;
      m_sb = '0;
    end else begin
      if (we && wa != ZERO_IDX)
        m_regs[wa] = wd;
      if (we)
        m_sb[wa] = 1'b0;
      if (iv && id != ZERO_IDX)
        m_sb[id] = 1'b1;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("rdata1", bus.ReadData1, e.d1);
    chk("rdata2", bus.ReadData2, e.d2);
    chk("rvalid", {63'd0, bus.ReadValid}, {63'd0, e.v});
  endtask

  task automatic idle_rd(input reg_idx_t r1,
                         input reg_idx_t r2);
    step(1, 0, 0, 0, 1, r1, r2, 0, 0);
  endtask

  initial begin
    m_sb = '0;
    last.d1 = '0; last.d2 = '0; last.v = 1'b0;
    // reset overrides write and issue
    step(0, 1, 3, 64'hDEAD, 1, 3, 3, 1, 3);
    step(0, 1, 3, 64'hDEAD, 1, 3, 3, 1, 3);
    idle_rd(3, 0);
    chk("rst_r3", bus.ReadData1, 64'd0);
    chk("rst_v", {63'd0, bus.ReadValid}, 64'd1);
    chk("rst_busy", {63'd0, bus.Busy1}, 64'd0);

    step(1, 1, 5, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0);
    idle_rd(5, 0);
    chk("wr5", bus.ReadData1, 64'h0123456789ABCDEF);
    step(1, 0, 0, 0, 0, 5, 0, 0, 0);
    chk("hold5", bus.ReadData1, 64'h0123456789ABCDEF);
    chk("hold_v", {63'd0, bus.ReadValid}, 64'd0);

    step(1, 1, 31, '1, 0, 0, 0, 0, 0);
    idle_rd(31, 31);
    chk("xzr1", bus.ReadData1, 64'd0);
    chk("xzr2", bus.ReadData2, 64'd0);
    step(1, 0, 0, 0, 0, 31, 31, 1, 31);
    chk("xzr_busy", {63'd0, bus.Busy1}, 64'd0);

    step(1, 1, 7, 64'h11, 0, 0, 0, 0, 0);
    step(1, 1, 7, 64'h22, 1, 7, 7, 0, 0);
    chk("same7", bus.ReadData1, BYP ? 64'h22 : 64'h11);
    idle_rd(7, 0);
    chk("after7", bus.ReadData1, 64'h22);

    step(1, 0, 0, 0, 0, 9, 0, 1, 9);
    chk("sb_set", {63'd0, bus.Busy1}, 64'd1);
    step(1, 1, 9, 64'h99, 0, 9, 0, 0, 0);
    chk("sb_clr", {63'd0, bus.Busy1}, 64'd0);
    step(1, 1, 9, 64'h9A, 0, 9, 0, 1, 9);
    step(1, 0, 0, 0, 0, 9, 0, 0, 0);
    chk("sb_win", {63'd0, bus.Busy1}, 64'd1);
    step(1, 1, 9, 64'h9B, 0, 9, 0, 0, 0);

    step(1, 1, 12, 64'hABCD, 0, 0, 0, 1, 12);
    idle_rd(12, 12);
    chk("dual1", bus.ReadData1, 64'hABCD);
    chk("dual2", bus.ReadData2, 64'hABCD);
    chk("dual_busy", {63'd0, bus.Busy1},
        {63'd0, bus.Busy2});

    // reset mid-operation drops pending producers
    step(1, 0, 0, 0, 0, 20, 0, 1, 20);
    step(0, 0, 0, 0, 0, 20, 0, 0, 0);
    step(1, 0, 0, 0, 1, 20, 12, 0, 0);
    chk("rst_sb", {63'd0, bus.Busy1}, 64'd0);
    chk("rst_r12", bus.ReadData2, 64'd0);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 1)),
           reg_idx_t'($urandom_range(0, 7) + 24),
           {$urandom, $urandom},
           1'($urandom_range(0, 1)),
           reg_idx_t'($urandom_range(0, 7) + 24),
           reg_idx_t'($urandom_range(0, 7) + 24),
           1'($urandom_range(0, 1)),
           reg_idx_t'($urandom_range(0, 7) + 24));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
